// File: rtl/jtdd_rom_pkg.sv
// Shared definitions for the Double Dragon ROM arbiter: SDRAM address width,
// default region offsets, FSM encoding and the round-robin pick helper.
package jtdd_rom_pkg;

    localparam int SDRAM_AW = 22;

    localparam logic [SDRAM_AW-1:0] OFS0_DEF = 22'h000000;
    localparam logic [SDRAM_AW-1:0] OFS1_DEF = 22'h020000;
    localparam logic [SDRAM_AW-1:0] OFS2_DEF = 22'h028000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } grant_t;

    // Search starts at the requester after 'last' and wraps 0,1,2.
    function automatic grant_t rr_pick(input logic [2:0] miss, input logic [1:0] last);
        grant_t     g;
        logic [1:0] cand;
        g    = '0;
        cand = last;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!g.found && miss[cand]) begin
                g.found = 1'b1;
                g.idx   = cand;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/jtdd_rom_arb_if.sv
// SDRAM read-port handshake between the ROM arbiter (master) and the SDRAM
// controller (slave).
interface jtdd_rom_arb_if;

    logic                            sdram_req;
    logic [jtdd_rom_pkg::SDRAM_AW-1:0] sdram_addr;
    logic                            sdram_ack;
    logic                            data_rdy;
    logic [15:0]                     data_read;

    modport master (
        output sdram_req,
        output sdram_addr,
        input  sdram_ack,
        input  data_rdy,
        input  data_read
    );

    modport slave (
        input  sdram_req,
        input  sdram_addr,
        output sdram_ack,
        output data_rdy,
        output data_read
    );

endinterface

// File: rtl/jtdd_rom_slot.sv
// One-word ROM cache for a single requester: hit compare, byte select, and a
// pending tag captured at grant so a fill always uses the granted address.
module jtdd_rom_slot #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          load,
    input  logic          fill,
    input  logic [15:0]   fill_data,
    input  logic [AW-1:0] addr,
    output logic          hit,
    output logic [7:0]    data
);

    logic          valid;
    logic [AW-2:0] tag;
    logic [AW-2:0] pend_tag;
    logic [15:0]   word;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the cache word is reset too, so data reads 00
    // out of reset instead of X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            tag      <= '0;
            pend_tag <= '0;
            word     <= '0;
        end else begin
            if (load) pend_tag <= addr[AW-1:1];
            if (flush) begin
                valid <= 1'b0;
            end else if (fill) begin
                valid <= 1'b1;
                tag   <= pend_tag;
                word  <= fill_data;
            end
        end
    end

    assign hit  = valid & (tag == addr[AW-1:1]);
    assign data = addr[0] ? word[15:8] : word[7:0];

endmodule

// File: rtl/jtdd_rom_arb.sv
// Shares the SDRAM read port among the main CPU, sound CPU and MCU ROMs:
// per-requester one-word cache, round-robin miss service, one transaction at a time.
module jtdd_rom_arb
    import jtdd_rom_pkg::*;
#(
    parameter int                  AW0  = 18,
    parameter int                  AW1  = 15,
    parameter int                  AW2  = 14,
    parameter logic [SDRAM_AW-1:0] OFS0 = OFS0_DEF,
    parameter logic [SDRAM_AW-1:0] OFS1 = OFS1_DEF,
    parameter logic [SDRAM_AW-1:0] OFS2 = OFS2_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            downloading,
    input  logic            r0_cs,
    input  logic [AW0-1:0]  r0_addr,
    output logic [7:0]      r0_data,
    output logic            r0_ok,
    input  logic            r1_cs,
    input  logic [AW1-1:0]  r1_addr,
    output logic [7:0]      r1_data,
    output logic            r1_ok,
    input  logic            r2_cs,
    input  logic [AW2-1:0]  r2_addr,
    output logic [7:0]      r2_data,
    output logic            r2_ok,
    jtdd_rom_arb_if.master  sdram
);

    state_t              state, state_nx;
    logic [1:0]          lat_id;
    logic [1:0]          last_grant;
    logic [2:0]          hit, miss, load, fill;
    logic                take, done;
    grant_t              pick;
    logic [SDRAM_AW-1:0] grant_addr [0:2];

    assign miss[0] = r0_cs & ~hit[0] & ~downloading;
    assign miss[1] = r1_cs & ~hit[1] & ~downloading;
    assign miss[2] = r2_cs & ~hit[2] & ~downloading;

    assign r0_ok = r0_cs & hit[0] & ~downloading;
    assign r1_ok = r1_cs & hit[1] & ~downloading;
    assign r2_ok = r2_cs & hit[2] & ~downloading;

    assign pick = rr_pick(miss, last_grant);

    // Region offset plus word index; the sum wraps at 2^22.
    assign grant_addr[0] = OFS0 + SDRAM_AW'(r0_addr[AW0-1:1]);
    assign grant_addr[1] = OFS1 + SDRAM_AW'(r1_addr[AW1-1:1]);
    assign grant_addr[2] = OFS2 + SDRAM_AW'(r2_addr[AW2-1:1]);

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (pick.found) begin
                    take     = 1'b1;
                    state_nx = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram.sdram_ack) begin
                    if (sdram.data_rdy) begin
                        done     = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (sdram.data_rdy) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            lat_id           <= 2'd0;
            last_grant       <= 2'd2;
            sdram.sdram_addr <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                lat_id           <= pick.idx;
                sdram.sdram_addr <= grant_addr[pick.idx];
            end
            if (done) last_grant <= lat_id;
        end
    end

    assign sdram.sdram_req = (state == WAIT_ACK);

    // Data arriving while downloading is dropped; the flush wins anyway.
    assign load[0] = take & (pick.idx == 2'd0);
    assign load[1] = take & (pick.idx == 2'd1);
    assign load[2] = take & (pick.idx == 2'd2);
    assign fill[0] = done & ~downloading & (lat_id == 2'd0);
    assign fill[1] = done & ~downloading & (lat_id == 2'd1);
    assign fill[2] = done & ~downloading & (lat_id == 2'd2);

    jtdd_rom_slot #(.AW(AW0)) u_slot0 (
        .clk(clk), .rst_n(rst_n), .flush(downloading), .load(load[0]), .fill(fill[0]),
        .fill_data(sdram.data_read), .addr(r0_addr), .hit(hit[0]), .data(r0_data)
    );

    jtdd_rom_slot #(.AW(AW1)) u_slot1 (
        .clk(clk), .rst_n(rst_n), .flush(downloading), .load(load[1]), .fill(fill[1]),
        .fill_data(sdram.data_read), .addr(r1_addr), .hit(hit[1]), .data(r1_data)
    );

    jtdd_rom_slot #(.AW(AW2)) u_slot2 (
        .clk(clk), .rst_n(rst_n), .flush(downloading), .load(load[2]), .fill(fill[2]),
        .fill_data(sdram.data_read), .addr(r2_addr), .hit(hit[2]), .data(r2_data)
    );

endmodule
